apb_cmd_master: RTL and testbench



---
 rtl/apb_cmd_master_if.sv | 41 ++++
 rtl/apb_cmd_master.sv | 152 +++++++++++++++
 tb/tb_apb_cmd_master.sv | 255 +++++++++++++++++++++++++
 3 files changed

// File: rtl/apb_cmd_master_if.sv
// Bundle for apb_cmd_master: command/response handshake plus the APB initiator signals.
// The master modport is the block's own view; slave is the view of the environment around it.
interface apb_cmd_master_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  // Command handshake
  logic              cmd_valid;
  logic              cmd_ready;
  logic              cmd_write;
  logic [ADDR_W-1:0] cmd_addr;
  logic [DATA_W-1:0] cmd_wdata;

  // Response handshake
  logic              rsp_valid;
  logic              rsp_ready;
  logic              rsp_write;
  logic [DATA_W-1:0] rsp_rdata;
  logic              rsp_timeout;

  // APB
  logic [ADDR_W-1:0] PADDR;
  logic              PSEL;
  logic              PENABLE;
  logic              PWRITE;
  logic [DATA_W-1:0] PWDATA;
  logic [DATA_W-1:0] PRDATA;
  logic              PREADY;

  modport master (
    input  cmd_valid, cmd_write, cmd_addr, cmd_wdata, rsp_ready, PRDATA, PREADY,
    output cmd_ready, rsp_valid, rsp_write, rsp_rdata, rsp_timeout,
           PADDR, PSEL, PENABLE, PWRITE, PWDATA
  );

  modport slave (
    output cmd_valid, cmd_write, cmd_addr, cmd_wdata, rsp_ready, PRDATA, PREADY,
    input  cmd_ready, rsp_valid, rsp_write, rsp_rdata, rsp_timeout,
           PADDR, PSEL, PENABLE, PWRITE, PWDATA
  );
endinterface

// File: rtl/apb_cmd_master.sv
// APB initiator: one command in, one APB transfer out, one response back; single outstanding.
// Optional ACCESS-phase timeout abort is compiled in with `define APB_TIMEOUT_EN.
module apb_cmd_master #(
  parameter int ADDR_W         = 32,
  parameter int DATA_W         = 32,
  parameter int TIMEOUT_CYCLES = 256
) (
  input  logic             pclk,
  input  logic             PRESETn,
  apb_cmd_master_if.master bus
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETUP  = 2'd1,
    ACCESS = 2'd2,
    RESP   = 2'd3
  } state_e;

  state_e            r_state;
  state_e            w_next;

  logic [ADDR_W-1:0] r_paddr;
  logic              r_pwrite;
  logic [DATA_W-1:0] r_pwdata;
  logic              r_rsp_write;
  logic [DATA_W-1:0] r_rsp_rdata;

  logic              w_accept;
  logic              w_done;
  logic              w_timeout;

  logic              w_psel;
  logic              w_penable;
  logic              w_cmd_ready;
  logic              w_rsp_valid;

  assign w_accept = (r_state == IDLE) && bus.cmd_valid;
  assign w_done   = (r_state == ACCESS) && bus.PREADY;

`ifdef APB_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);

  logic [CNT_W-1:0] r_wait_cnt;
  logic             r_rsp_timeout;

  // Cleared while in SETUP so every ACCESS phase starts counting from zero.
  always_ff @(posedge pclk or negedge PRESETn) begin
    if (!PRESETn) begin
      r_wait_cnt <= '0;
    end else if (r_state == SETUP) begin
      r_wait_cnt <= '0;
    end else if ((r_state == ACCESS) && !bus.PREADY) begin
      r_wait_cnt <= r_wait_cnt + 1'b1;
    end
  end

  // This edge brings the count to the limit; PREADY high on it wins as a normal completion.
  assign w_timeout = (r_state == ACCESS) && !bus.PREADY &&
                     (r_wait_cnt == CNT_W'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge pclk or negedge PRESETn) begin
    if (!PRESETn) begin
      r_rsp_timeout <= 1'b0;
    end else if (w_done || w_timeout) begin
      r_rsp_timeout <= w_timeout;
    end
  end

  assign bus.rsp_timeout = r_rsp_timeout;
`else
  assign w_timeout       = 1'b0;
  assign bus.rsp_timeout = 1'b0;

  // TIMEOUT_CYCLES stays in the parameter list so both builds share one instantiation.
  if (TIMEOUT_CYCLES < 1) begin : g_timeout_cfg_unused
  end
`endif

  // State register
  always_ff @(posedge pclk or negedge PRESETn) begin
    if (!PRESETn) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // Next-state logic
  always_comb begin
    // NOTE: default assignment first so no path through the case leaves w_next unassigned (no latch).
    w_next = r_state;
    case (r_state)
      IDLE:    if (bus.cmd_valid)             w_next = SETUP;
      SETUP:                                  w_next = ACCESS;
      ACCESS:  if (bus.PREADY || w_timeout)   w_next = RESP;
      RESP:    if (bus.rsp_ready)             w_next = IDLE;
      default:                                w_next = IDLE;
    endcase
  end

  // Control outputs decoded from the state register only
  always_comb begin
    w_psel      = 1'b0;
    w_penable   = 1'b0;
    w_cmd_ready = 1'b0;
    w_rsp_valid = 1'b0;
    case (r_state)
      IDLE:    w_cmd_ready = 1'b1;
      SETUP:   w_psel      = 1'b1;
      ACCESS: begin
        w_psel    = 1'b1;
        w_penable = 1'b1;
      end
      RESP:    w_rsp_valid = 1'b1;
      default: w_cmd_ready = 1'b0;
    endcase
  end

  // Command capture and response capture
  always_ff @(posedge pclk or negedge PRESETn) begin
    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    if (!PRESETn) begin
      r_paddr     <= '0;
      r_pwrite    <= 1'b0;
      r_pwdata    <= '0;
      r_rsp_write <= 1'b0;
      r_rsp_rdata <= '0;
    end else begin
      if (w_accept) begin
        r_paddr  <= bus.cmd_addr;
        r_pwrite <= bus.cmd_write;
        r_pwdata <= bus.cmd_wdata;
      end
      if (w_done || w_timeout) begin
        r_rsp_write <= r_pwrite;
        r_rsp_rdata <= (w_done && !r_pwrite) ? bus.PRDATA : '0;
      end
    end
  end

  assign bus.PADDR     = r_paddr;
  assign bus.PWRITE    = r_pwrite;
  assign bus.PWDATA    = r_pwdata;
  assign bus.PSEL      = w_psel;
  assign bus.PENABLE   = w_penable;
  assign bus.cmd_ready = w_cmd_ready;
  assign bus.rsp_valid = w_rsp_valid;
  assign bus.rsp_write = r_rsp_write;
  assign bus.rsp_rdata = r_rsp_rdata;

endmodule

// File: tb/tb_apb_cmd_master.sv
// Self-checking bench for apb_cmd_master: directed and randomized transfers against a
// transaction-level expectation (phase lengths, response contents) derived from the protocol rules.
module tb_apb_cmd_master;

  localparam int ADDR_W = 32;
  localparam int DATA_W = 32;
  localparam int TMO    = 8;
`ifdef APB_TIMEOUT_EN
  localparam bit TMO_EN = 1'b1;
`else
  localparam bit TMO_EN = 1'b0;
`endif

  logic pclk    = 1'b0;
  logic PRESETn = 1'b0;

  int n_checks = 0;
  int n_errors = 0;

  apb_cmd_master_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

  apb_cmd_master #(
    .ADDR_W         (ADDR_W),
    .DATA_W         (DATA_W),
    .TIMEOUT_CYCLES (TMO)
  ) dut (
    .pclk    (pclk),
    .PRESETn (PRESETn),
    .bus     (bus)
  );

  always #5 pclk = ~pclk;

  // Back-to-back bookkeeping
  logic [31:0] b2b_addr [4];
  logic [31:0] b2b_data [4];
  int          n_sent;
  int          n_pulses;
  int          last_rise;
  logic        prev_psel;

  task automatic tick();
    @(negedge pclk);
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic check_idle(input string tag);
    check({tag, "_cmd_ready"}, bus.cmd_ready, 1);
    check({tag, "_psel"},      bus.PSEL,      0);
    check({tag, "_penable"},   bus.PENABLE,   0);
    check({tag, "_rsp_valid"}, bus.rsp_valid, 0);
  endtask

  // One complete transfer starting at a negedge with the DUT idle. waits = number of ACCESS
  // cycles with PREADY low before the completer raises it; rsp_hold = cycles rsp_ready stays low.
  // With chain set, the next command is presented right after accept and held throughout.
  task automatic run_txn(input bit wr, input logic [31:0] addr, input logic [31:0] wdata,
                         input logic [31:0] prdata, input int waits, input int rsp_hold,
                         input bit chain, input bit nwr, input logic [31:0] naddr,
                         input logic [31:0] nwdata);
    bit          tmo;
    int          n_acc;
    logic [31:0] exp_rdata;
    tmo       = TMO_EN && (waits >= TMO);
    n_acc     = tmo ? TMO : waits + 1;
    exp_rdata = (wr || tmo) ? 32'h0 : prdata;

    check("accept_ready", bus.cmd_ready, 1);
    bus.cmd_valid = 1'b1;
    bus.cmd_write = wr;
    bus.cmd_addr  = addr;
    bus.cmd_wdata = wdata;
    tick();

    if (chain) begin
      bus.cmd_write = nwr;
      bus.cmd_addr  = naddr;
      bus.cmd_wdata = nwdata;
    end else begin
      bus.cmd_valid = 1'b0;
      bus.cmd_write = ~wr;
      bus.cmd_addr  = $urandom;
      bus.cmd_wdata = $urandom;
    end

    // SETUP: one cycle after accept
    check("setup_psel",    bus.PSEL,      1);
    check("setup_penable", bus.PENABLE,   0);
    check("setup_ready",   bus.cmd_ready, 0);
    check("setup_paddr",   bus.PADDR,     addr);
    check("setup_pwrite",  bus.PWRITE,    wr);
    check("setup_pwdata",  bus.PWDATA,    wdata);
    bus.PREADY = 1'($urandom_range(0, 1));
    bus.PRDATA = $urandom;

    for (int i = 0; i < n_acc; i++) begin
      tick();
      check("access_psel",    bus.PSEL,      1);
      check("access_penable", bus.PENABLE,   1);
      check("access_paddr",   bus.PADDR,     addr);
      check("access_pwdata",  bus.PWDATA,    wdata);
      check("access_rsp_v",   bus.rsp_valid, 0);
      bus.PREADY = (i == waits);
      bus.PRDATA = (i == waits) ? prdata : $urandom;
    end
    tick();
    bus.PREADY = 1'($urandom_range(0, 1));
    bus.PRDATA = $urandom;

    check("resp_psel",    bus.PSEL,        0);
    check("resp_penable", bus.PENABLE,     0);
    check("resp_valid",   bus.rsp_valid,   1);
    check("resp_write",   bus.rsp_write,   wr);
    check("resp_rdata",   bus.rsp_rdata,   exp_rdata);
    check("resp_timeout", bus.rsp_timeout, tmo);
    check("resp_paddr",   bus.PADDR,       addr);

    bus.rsp_ready = 1'b0;
    for (int i = 0; i < rsp_hold; i++) begin
      tick();
      check("hold_valid", bus.rsp_valid, 1);
      check("hold_rdata", bus.rsp_rdata, exp_rdata);
      check("hold_ready", bus.cmd_ready, 0);
      check("hold_psel",  bus.PSEL,      0);
    end
    bus.rsp_ready = 1'b1;
    tick();
    bus.rsp_ready = 1'b0;
    bus.PREADY    = 1'b0;
    check_idle("post_resp");
  endtask

  initial begin
    bus.cmd_valid = 1'b0;
    bus.cmd_write = 1'b0;
    bus.cmd_addr  = '0;
    bus.cmd_wdata = '0;
    bus.rsp_ready = 1'b0;
    bus.PRDATA    = '0;
    bus.PREADY    = 1'b0;

    // Reset values
    tick();
    tick();
    check_idle("reset");
    check("reset_paddr",   bus.PADDR,       0);
    check("reset_pwdata",  bus.PWDATA,      0);
    check("reset_pwrite",  bus.PWRITE,      0);
    check("reset_rsp_w",   bus.rsp_write,   0);
    check("reset_rdata",   bus.rsp_rdata,   0);
    check("reset_timeout", bus.rsp_timeout, 0);
    PRESETn = 1'b1;
    tick();
    check_idle("after_reset");

    // Write, no wait states
    run_txn(1'b1, 32'h000, 32'h0000_00FF, 32'hDEAD_BEEF, 0, 0, 1'b0, 1'b0, '0, '0);
    // Read with 3 wait states
    run_txn(1'b0, 32'hC00, 32'h1234_5678, 32'h0000_0001, 3, 0, 1'b0, 1'b0, '0, '0);

    // Back-pressure: second command held while the response waits 5 cycles
    run_txn(1'b0, 32'h0000_0A10, 32'h0, 32'hCAFE_0001, 1, 5, 1'b1, 1'b1, 32'h0000_0B20, 32'h5555_AAAA);
    run_txn(1'b1, 32'h0000_0B20, 32'h5555_AAAA, 32'h0, 0, 0, 1'b0, 1'b0, '0, '0);

    // Back-to-back: 4 writes, rsp_ready and PREADY held high
    for (int i = 0; i < 4; i++) begin
      b2b_addr[i] = 32'h100 + 32'(i) * 32'h4;
      b2b_data[i] = $urandom;
    end
    bus.rsp_ready = 1'b1;
    bus.PREADY    = 1'b1;
    n_sent    = 0;
    n_pulses  = 0;
    last_rise = -1;
    prev_psel = 1'b0;
    for (int cyc = 0; cyc < 24; cyc++) begin
      if (bus.PSEL && !prev_psel) begin
        if (n_pulses < 4) begin
          check("b2b_paddr",  bus.PADDR,  b2b_addr[n_pulses]);
          check("b2b_pwdata", bus.PWDATA, b2b_data[n_pulses]);
        end
        if (n_pulses > 0) check("b2b_spacing", 64'(cyc - last_rise), 4);
        last_rise = cyc;
        n_pulses++;
      end
      prev_psel = bus.PSEL;
      if (bus.cmd_ready && n_sent < 4) begin
        bus.cmd_valid = 1'b1;
        bus.cmd_write = 1'b1;
        bus.cmd_addr  = b2b_addr[n_sent];
        bus.cmd_wdata = b2b_data[n_sent];
        n_sent++;
      end else if (bus.cmd_ready) begin
        bus.cmd_valid = 1'b0;
      end
      tick();
    end
    check("b2b_pulses", 64'(n_pulses), 4);
    bus.cmd_valid = 1'b0;
    bus.rsp_ready = 1'b0;
    bus.PREADY    = 1'b0;
    tick();
    check_idle("b2b_end");

    // Randomized transfers
    for (int n = 0; n < 12; n++) begin
      run_txn(1'($urandom_range(0, 1)), $urandom, $urandom, $urandom,
              int'($urandom_range(0, TMO_EN ? 10 : 6)), int'($urandom_range(0, 2)),
              1'b0, 1'b0, '0, '0);
    end

    // Timeout boundary: PREADY rising on the last allowed ACCESS cycle, then stuck low
    run_txn(1'b0, 32'h0000_0F00, 32'h0, 32'h0BAD_F00D, TMO - 1, 0, 1'b0, 1'b0, '0, '0);
    run_txn(1'b0, 32'h0000_0F04, 32'h0, 32'h0BAD_F00E, TMO, 1, 1'b0, 1'b0, '0, '0);
    run_txn(1'b1, 32'h0000_0F08, 32'h7777_0000, 32'h0, TMO + 12, 0, 1'b0, 1'b0, '0, '0);

    // Reset during an ACCESS stall
    bus.cmd_valid = 1'b1;
    bus.cmd_write = 1'b0;
    bus.cmd_addr  = 32'h0000_0ABC;
    bus.cmd_wdata = 32'h0;
    bus.PREADY    = 1'b0;
    tick();
    bus.cmd_valid = 1'b0;
    tick();
    tick();
    check("stall_psel",    bus.PSEL,    1);
    check("stall_penable", bus.PENABLE, 1);
    #2 PRESETn = 1'b0;
    #1;
    check("async_psel",    bus.PSEL,      0);
    check("async_penable", bus.PENABLE,   0);
    check("async_rsp_v",   bus.rsp_valid, 0);
    tick();
    tick();
    PRESETn = 1'b1;
    tick();
    check_idle("rst_release");
    check("rst_paddr", bus.PADDR, 0);

    // Normal operation after the reset
    run_txn(1'b0, 32'h0000_0C00, 32'h0, 32'h89AB_CDEF, 2, 1, 1'b0, 1'b0, '0, '0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
